// File: rtl/usr_access_pkg.sv
// Shared constants for the user-access word buffer: overflow policies,
// default widths and the pointer-width helper.
package usr_access_pkg;

  localparam int unsigned OVF_DROP_NEW    = 0;
  localparam int unsigned OVF_DROP_OLDEST = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/usr_access_fifo_mem.sv
// DEPTH x DATA_W circular store with read/write pointers and occupancy.
// Exposes next-cycle level and head word so the parent can register out_data.
module usr_access_fifo_mem
  import usr_access_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    write,
  input  logic                    advance,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [ptr_w(DEPTH):0]   level,
  output logic [ptr_w(DEPTH):0]   level_next,
  output logic [DATA_W-1:0]       head_next
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;

  always_ff @(posedge clock) begin
    if (write) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      level  <= level_next;
    end
  end

  always_comb begin
    rd_next    = rd_ptr;
    level_next = level;
    if (advance && !clear) rd_next = rd_ptr + PW'(1);
    if (clear)                  level_next = '0;
    else if (write && !advance) level_next = level + LW'(1);
    else if (advance && !write) level_next = level - LW'(1);
  end

  // A word written this cycle into the slot that becomes head must be forwarded.
  always_comb begin
    head_next = mem[rd_next];
    if (write && (wr_ptr == rd_next)) head_next = wr_data;
  end

endmodule

// File: rtl/usr_access_word_buffer.sv
// Capture buffer for configuration user-access words with valid/ready output,
// overflow policy and accepted-word counter. Optional: USR_ACCESS_CHANGE_FILTER_EN.
module usr_access_word_buffer
  import usr_access_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DROP_OLDEST = OVF_DROP_NEW,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    clear,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        word_count
);

  localparam int unsigned LW       = ptr_w(DEPTH) + 1;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam bit            DROP_OLD = (DROP_OLDEST == OVF_DROP_OLDEST);

  logic              push;
  logic              pop;
  logic              full;
  logic              write;
  logic              advance;
  logic              ovf_event;
  logic [LW-1:0]     level_next;
  logic [DATA_W-1:0] head_next;

`ifdef USR_ACCESS_CHANGE_FILTER_EN
  logic [DATA_W-1:0] last_word;
  logic              last_valid;

  assign push = in_valid && (!last_valid || (in_data != last_word));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_word  <= '0;
      last_valid <= 1'b0;
    end else if (clear) begin
      last_valid <= 1'b0;
    end else if (write) begin
      last_word  <= in_data;
      last_valid <= 1'b1;
    end
  end
`else
  assign push = in_valid;
`endif

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (level == FULL);
  assign write     = push && !clear && (!full || pop || DROP_OLD);
  // Drop-oldest on a full FIFO retires the head even without a pop.
  assign advance   = !clear && (pop || (push && full && !pop && DROP_OLD));
  assign ovf_event = push && full && !pop && !clear;

  usr_access_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .write      (write),
    .advance    (advance),
    .wr_data    (in_data),
    .level      (level),
    .level_next (level_next),
    .head_next  (head_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (level_next != '0) out_data <= head_next;
      if (ovf_event)        overflow <= 1'b1;
      if (write)            word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_usr_access_word_buffer.sv
// Directed bench: one drop-new instance (CNT_W=16) and one drop-oldest
// instance (CNT_W=3) driven by the same stimulus.
module tb_usr_access_word_buffer;

  logic        clock;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        clear;
  logic        out_ready;

  logic [31:0] a_out_data, b_out_data;
  logic        a_out_valid, b_out_valid;
  logic [2:0]  a_level, b_level;
  logic        a_overflow, b_overflow;
  logic [15:0] a_word_count;
  logic [2:0]  b_word_count;

  int vectors = 0;
  int miscompares = 0;

  usr_access_word_buffer #(
    .DATA_W(32), .DEPTH(4), .DROP_OLDEST(0), .CNT_W(16)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .clear(clear), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .level(a_level), .overflow(a_overflow),
    .word_count(a_word_count)
  );

  usr_access_word_buffer #(
    .DATA_W(32), .DEPTH(4), .DROP_OLDEST(1), .CNT_W(3)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .clear(clear), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .level(b_level), .overflow(b_overflow),
    .word_count(b_word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
  endtask

`ifdef USR_ACCESS_CHANGE_FILTER_EN
  logic [31:0] filt_exp [3] = '{32'h1, 32'h2, 32'h1};
`endif

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    chk("rst_out_data",  a_out_data, 32'h0);
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("rst_level",     {29'b0, a_level}, 32'h0);
    chk("rst_overflow",  {31'b0, a_overflow}, 32'h0);
    chk("rst_count",     {16'b0, a_word_count}, 32'h0);
    chk("rst_b_level",   {29'b0, b_level}, 32'h0);
    reset_n = 1'b1;
    step();

    // single word, one-cycle latency, then popped
    out_ready = 1'b1;
    push(32'hDEADBEEF);
    chk("t1_valid", {31'b0, a_out_valid}, 32'h1);
    chk("t1_data",  a_out_data, 32'hDEADBEEF);
    chk("t1_level", {29'b0, a_level}, 32'h1);
    in_valid = 1'b0;
    step();
    chk("t1_level_after", {29'b0, a_level}, 32'h0);
    chk("t1_valid_after", {31'b0, a_out_valid}, 32'h0);
    chk("t1_data_hold",   a_out_data, 32'hDEADBEEF);
    chk("t1_count",       {16'b0, a_word_count}, 32'h1);

    // overflow with both policies
    out_ready = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 1; i <= 5; i++) push(32'(i));
    in_valid = 1'b0;
    chk("ovf_a_level", {29'b0, a_level}, 32'h4);
    chk("ovf_a_flag",  {31'b0, a_overflow}, 32'h1);
    chk("ovf_a_count", {16'b0, a_word_count}, 32'h4);
    chk("ovf_a_head",  a_out_data, 32'h1);
    chk("ovf_b_level", {29'b0, b_level}, 32'h4);
    chk("ovf_b_flag",  {31'b0, b_overflow}, 32'h1);
    chk("ovf_b_count", {29'b0, b_word_count}, 32'h5);
    chk("ovf_b_head",  b_out_data, 32'h2);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_a_drain", a_out_data, 32'(k + 1));
      chk("ovf_b_drain", b_out_data, 32'(k + 2));
      step();
    end
    chk("ovf_a_empty",  {31'b0, a_out_valid}, 32'h0);
    chk("ovf_b_empty",  {31'b0, b_out_valid}, 32'h0);
    chk("ovf_sticky",   {31'b0, a_overflow}, 32'h1);

    // full FIFO, simultaneous push and pop
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_overflow", {31'b0, a_overflow}, 32'h0);
    chk("clr_a_count",  {16'b0, a_word_count}, 32'h0);
    chk("clr_b_count",  {29'b0, b_word_count}, 32'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
    out_ready = 1'b1;
    push(32'h14);
    in_valid = 1'b0;
    chk("pp_a_level", {29'b0, a_level}, 32'h4);
    chk("pp_b_level", {29'b0, b_level}, 32'h4);
    chk("pp_a_ovf",   {31'b0, a_overflow}, 32'h0);
    chk("pp_b_ovf",   {31'b0, b_overflow}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("pp_a_drain", a_out_data, 32'h11 + 32'(k));
      chk("pp_b_drain", b_out_data, 32'h11 + 32'(k));
      step();
    end
    chk("pp_a_count", {16'b0, a_word_count}, 32'h5);
    chk("pp_b_count", {29'b0, b_word_count}, 32'h5);

    // clear with queued entries and a concurrent push
    out_ready = 1'b0;
    push(32'h20); push(32'h21); push(32'h22);
    chk("cq_level", {29'b0, a_level}, 32'h3);
    clear = 1'b1;
    push(32'h23);
    clear = 1'b0; in_valid = 1'b0;
    chk("cq_level0", {29'b0, a_level}, 32'h0);
    chk("cq_valid0", {31'b0, a_out_valid}, 32'h0);
    chk("cq_count0", {16'b0, a_word_count}, 32'h0);
    chk("cq_b_level0", {29'b0, b_level}, 32'h0);
    step();
    chk("cq_push_dropped", {29'b0, a_level}, 32'h0);

    // streaming with pop every cycle; 3-bit counter wraps
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(32'h30 + 32'(i));
    chk("wr_a_count", {16'b0, a_word_count}, 32'h9);
    chk("wr_b_count", {29'b0, b_word_count}, 32'h1);
    chk("wr_level",   {29'b0, a_level}, 32'h1);
    chk("wr_data",    a_out_data, 32'h38);
    in_valid = 1'b0;
    step();
    chk("wr_level0", {29'b0, a_level}, 32'h0);

    // repeated words: change filter behaviour
    out_ready = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    push(32'h1); push(32'h1); push(32'h2); push(32'h2); push(32'h1);
    in_valid = 1'b0;
`ifdef USR_ACCESS_CHANGE_FILTER_EN
    chk("flt_a_count", {16'b0, a_word_count}, 32'h3);
    chk("flt_b_count", {29'b0, b_word_count}, 32'h3);
    chk("flt_level",   {29'b0, a_level}, 32'h3);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("flt_drain", a_out_data, filt_exp[k]);
      step();
    end
`else
    chk("nof_a_count", {16'b0, a_word_count}, 32'h4);
    chk("nof_b_count", {29'b0, b_word_count}, 32'h5);
    chk("nof_level",   {29'b0, a_level}, 32'h4);
`endif

    // asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    push(32'h40); push(32'h41);
    in_data = 32'h42;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_data",  a_out_data, 32'h0);
    chk("ar_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("ar_level",     {29'b0, a_level}, 32'h0);
    chk("ar_overflow",  {31'b0, a_overflow}, 32'h0);
    chk("ar_count",     {16'b0, a_word_count}, 32'h0);
    chk("ar_b_level",   {29'b0, b_level}, 32'h0);
    step();
    chk("ar_hold_level", {29'b0, a_level}, 32'h0);
    reset_n = 1'b1; in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
